// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: shares one byte-wide UART transmit path between two
// 128-bit block sources. Arbitration is round-robin per whole frame.
// Each granted block is sent as SYNC, tag, then 16 data bytes MSB first.
// Optional feature macro: UART_FRAME_ARBITER_CHECKSUM_EN appends an XOR
// checksum byte covering the tag byte and the 16 data bytes.
module uart_frame_arbiter #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         IDLE_GAP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] req0_data,
    input  logic         req0_valid,
    output logic         req0_ack,
    input  logic [127:0] req1_data,
    input  logic         req1_valid,
    output logic         req1_ack,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_done,
    output logic         busy,
    output logic         frame_done,
    output logic         grant_id
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd18;
`else
    localparam logic [4:0] LAST_IDX = 5'd17;
`endif

    // Last GAP count value; unused when IDLE_GAP is zero.
    localparam logic [7:0] GAP_LAST = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

    logic [2:0]   state_r;
    logic [127:0] shadow_r;
    logic [4:0]   idx_r;
    logic [7:0]   gap_cnt_r;
    logic         last_grant_r;
    logic         req0_ack_r;
    logic         req1_ack_r;
    logic         tx_start_r;
    logic [7:0]   tx_data_r;
    logic         busy_r;
    logic         frame_done_r;
    logic         grant_id_r;
`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
    logic [7:0]   csum_r;
`endif

    logic [4:0]   next_idx_s;
    logic [7:0]   next_byte_s;
    logic         grant_s;

    // Byte at position idx (0..17) of the frame carrying blk.
    function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                              input logic [127:0] blk,
                                              input logic gid);
        logic [127:0] sh;
        sh = blk >> {(5'd17 - idx), 3'b000};
        case (idx)
            5'd0:    frame_byte = SYNC_BYTE;
            5'd1:    frame_byte = {7'b0000000, gid};
            default: frame_byte = sh[7:0];
        endcase
    endfunction

    assign req0_ack   = req0_ack_r;
    assign req1_ack   = req1_ack_r;
    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign grant_id   = grant_id_r;

    // Next byte to issue and round-robin winner for the idle state.
    always_comb begin
        next_idx_s = idx_r + 5'd1;
`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
        if (next_idx_s == LAST_IDX) begin
            next_byte_s = csum_r;
        end else begin
            next_byte_s = frame_byte(next_idx_s, shadow_r, grant_id_r);
        end
`else
        next_byte_s = frame_byte(next_idx_s, shadow_r, grant_id_r);
`endif
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = req1_valid;
        end
    end

    // Frame sequencer: grant, byte issue / tx_done handshake, done pulse, gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shadow_r     <= 128'd0;
            idx_r        <= 5'd0;
            gap_cnt_r    <= 8'd0;
            last_grant_r <= 1'b1;
            req0_ack_r   <= 1'b0;
            req1_ack_r   <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            grant_id_r   <= 1'b0;
`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            req0_ack_r   <= 1'b0;
            req1_ack_r   <= 1'b0;
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        shadow_r     <= grant_s ? req1_data : req0_data;
                        req0_ack_r   <= ~grant_s;
                        req1_ack_r   <= grant_s;
                        grant_id_r   <= grant_s;
                        last_grant_r <= grant_s;
                        idx_r        <= 5'd0;
                        busy_r       <= 1'b1;
                        tx_start_r   <= 1'b1;
                        tx_data_r    <= SYNC_BYTE;
`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
                        csum_r       <= 8'h00;
`endif
                        state_r      <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (idx_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            idx_r      <= next_idx_s;
                            tx_data_r  <= next_byte_s;
                            tx_start_r <= 1'b1;
`ifdef UART_FRAME_ARBITER_CHECKSUM_EN
                            csum_r     <= csum_r ^ next_byte_s;
`endif
                            state_r    <= ST_START;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    busy_r    <= 1'b0;
                    gap_cnt_r <= 8'd0;
                    if (IDLE_GAP > 0) begin
                        state_r <= ST_GAP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= 8'd0;
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                        state_r   <= ST_GAP;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
